// File: rtl/mod_cnt_pkg.sv
// Shared definitions for the modulo-N counter family.
//
// Contents:
//   cnt_state_t   run-control states: IDLE (00), RUN (01), DONE (10)
//   clamp_reload  value actually written on a parallel load: the requested
//                 value when it lies inside 0..modulus-1, otherwise the
//                 top of the range (modulus-1)
package mod_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } cnt_state_t;

  function automatic int unsigned clamp_reload(input int unsigned val,
                                               input int unsigned modulus);
    return (val < modulus) ? val : (modulus - 1);
  endfunction

endpackage

// File: rtl/mod_n_down_counter.sv
// Synchronous modulo-N down counter with run control.
//
// Counts MODULUS-1 down to 0 and then either wraps back to MODULUS-1 or,
// in one-shot mode, parks at 0 in the DONE state. Supports a parallel load
// with out-of-range detection, a terminal-count flag and a registered
// borrow pulse intended to drive the en input of the next digit in a
// cascaded chain.
//
// Optional build macro: MOD_N_DOWN_COUNTER_UPDN_EN
//   When defined, an extra input "up" selects increment (MODULUS-1 -> 0
//   wrap). borrow then acts as carry, one-shot stops at MODULUS-1 and tc
//   flags MODULUS-1 instead of 0.
//
// Ports:
//   clk       clock, rising edge active
//   rstn      asynchronous active-low reset
//   start     enter RUN from IDLE or DONE (oneshot sampled here)
//   stop      return to IDLE, count held; beats start and load
//   en        count-enable, only effective in RUN
//   load      parallel load request (any state, state unchanged)
//   load_val  value to load; out-of-range values clamp to MODULUS-1
//   oneshot   mode sampled on start: 1 = stop at terminal, 0 = wrap
//   up        (optional) count direction, 1 = increment
//   count     current count
//   tc        terminal count while in RUN (combinational)
//   borrow    one-cycle pulse after each terminal decrement
//   busy      state is RUN
//   done      state is DONE
//   load_err  sticky flag for an out-of-range load_val
module mod_n_down_counter
  import mod_cnt_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int MODULUS         = 14,
  parameter bit ONESHOT_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
`ifdef MOD_N_DOWN_COUNTER_UPDN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             borrow,
  output logic             busy,
  output logic             done,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // One bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  cnt_state_t       state;
  logic             oneshot_q;
  logic             cnt_up;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] wrap_val;
  logic             at_term;
  logic             load_bad;
  logic [WIDTH-1:0] reload_val;

`ifdef MOD_N_DOWN_COUNTER_UPDN_EN
  assign cnt_up = up;
`else
  assign cnt_up = 1'b0;
`endif

  // Terminal value is where the next enabled step wraps or finishes.
  assign term_val   = cnt_up ? MAX_VAL : '0;
  assign wrap_val   = cnt_up ? '0 : MAX_VAL;
  assign at_term    = (count == term_val);

  assign load_bad   = ({1'b0, load_val} >= MOD_EXT);
  assign reload_val = WIDTH'(clamp_reload(32'(load_val), 32'(MODULUS)));

  assign tc   = at_term && (state == RUN);
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      count     <= MAX_VAL;
      borrow    <= 1'b0;
      load_err  <= 1'b0;
      oneshot_q <= ONESHOT_DEFAULT;
    end else begin
      borrow <= 1'b0;
      if (stop) begin
        // stop overrides both start and a pending load.
        state <= IDLE;
      end else begin
        // start is ignored in RUN so the mode latch is not resampled.
        if (start && (state != RUN)) begin
          state     <= RUN;
          oneshot_q <= oneshot;
        end
        if (load) begin
          count    <= reload_val;
          load_err <= load_bad;
        end else if ((state == RUN) && en) begin
          if (at_term) begin
            borrow <= 1'b1;
            if (oneshot_q) begin
              state <= DONE;
            end else begin
              count <= wrap_val;
            end
          end else if (cnt_up) begin
            count <= count + 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Scoreboard bench for mod_n_down_counter (WIDTH=4, MODULUS=14).
// The stimulus process drives one cycle of inputs at each falling edge and
// queues the hand-derived output vector expected after the next rising
// edge; the monitor pops and compares shortly after every rising edge.
module tb_mod_n_down_counter;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       stop;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       oneshot;
  logic [3:0] count;
  logic       tc;
  logic       borrow;
  logic       busy;
  logic       done;
  logic       load_err;

  int checks;
  int errors;

  typedef struct {
    logic [8:0] v;
    string      nm;
  } exp_t;

  exp_t exp_q[$];

  mod_n_down_counter #(
    .WIDTH(4),
    .MODULUS(14),
    .ONESHOT_DEFAULT(1'b0)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .stop(stop),
    .en(en),
    .load(load),
    .load_val(load_val),
    .oneshot(oneshot),
    .count(count),
    .tc(tc),
    .borrow(borrow),
    .busy(busy),
    .done(done),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {count[3:0], tc, borrow, busy, done, load_err}
  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got cnt=%0d tc=%b bor=%b busy=%b done=%b lerr=%b, want cnt=%0d tc=%b bor=%b busy=%b done=%b lerr=%b",
               nm, act[8:5], act[4], act[3], act[2], act[1], act[0],
               expv[8:5], expv[4], expv[3], expv[2], expv[1], expv[0]);
    end
  endtask

  task automatic cyc(input logic rn, input logic s, input logic sp, input logic e,
                     input logic l, input logic [3:0] lv, input logic os,
                     input logic [3:0] c, input logic t, input logic b,
                     input logic bz, input logic dn, input logic le,
                     input string nm);
    exp_t x;
    @(negedge clk);
    rstn     = rn;
    start    = s;
    stop     = sp;
    en       = e;
    load     = l;
    load_val = lv;
    oneshot  = os;
    x.v  = {c, t, b, bz, dn, le};
    x.nm = nm;
    exp_q.push_back(x);
  endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check(x.nm, {count, tc, borrow, busy, done, load_err}, x.v);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL timeout: got still running, want finished");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int c;
    checks = 0;
    errors = 0;
    rstn = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
    load = 1'b0; load_val = 4'd0; oneshot = 1'b0;

    // Reset and release
    cyc(0, 0,0,0,0, 4'd0, 0,  4'd13, 0,0,0,0,0, "reset");
    cyc(0, 0,0,0,0, 4'd0, 0,  4'd13, 0,0,0,0,0, "reset_hold");
    cyc(1, 0,0,0,0, 4'd0, 0,  4'd13, 0,0,0,0,0, "release");

    // Free-running wrap mode
    cyc(1, 1,0,1,0, 4'd0, 0,  4'd13, 0,0,1,0,0, "start_wrap");
    for (int k = 1; k <= 30; k++) begin
      c = 13 - (k % 14);
      cyc(1, 0,0,1,0, 4'd0, 0,  4'(c), (c == 0), ((k % 14) == 0), 1,0,0, "wrap_run");
    end
    cyc(1, 0,1,1,0, 4'd0, 0,  4'd11, 0,0,0,0,0, "stop_hold");

    // One-shot from a loaded 3
    cyc(1, 0,0,0,1, 4'd3, 0,  4'd3, 0,0,0,0,0, "load3_idle");
    cyc(1, 1,0,1,0, 4'd0, 1,  4'd3, 0,0,1,0,0, "start_os");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd2, 0,0,1,0,0, "os_2");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd1, 0,0,1,0,0, "os_1");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd0, 1,0,1,0,0, "os_0");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd0, 0,1,0,1,0, "os_done");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd0, 0,0,0,1,0, "done_hold");
    cyc(1, 1,0,1,0, 4'd0, 1,  4'd0, 1,0,1,0,0, "restart_done");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd0, 0,1,0,1,0, "refinish");
    cyc(1, 0,1,0,0, 4'd0, 0,  4'd0, 0,0,0,0,0, "stop_done");

    // Wrap from 0, then loads in RUN
    cyc(1, 1,0,1,0, 4'd0, 0,  4'd0, 1,0,1,0,0, "start_wrap2");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd13, 0,1,1,0,0, "wrap_13");
    cyc(1, 0,0,1,1, 4'd15, 0, 4'd13, 0,0,1,0,1, "load15_run");
    cyc(1, 0,0,0,0, 4'd0, 0,  4'd13, 0,0,1,0,1, "err_sticky");
    cyc(1, 0,0,1,1, 4'd5, 0,  4'd5, 0,0,1,0,0, "load5_run");

    // Enable toggling from 13
    cyc(1, 0,0,1,1, 4'd13, 0, 4'd13, 0,0,1,0,0, "load13");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd12, 0,0,1,0,0, "en_1a");
    cyc(1, 0,0,0,0, 4'd0, 0,  4'd12, 0,0,1,0,0, "en_0a");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd11, 0,0,1,0,0, "en_1b");
    cyc(1, 0,0,0,0, 4'd0, 0,  4'd11, 0,0,1,0,0, "en_0b");

    // stop mid-run, start+stop together in IDLE
    cyc(1, 0,0,1,1, 4'd8, 0,  4'd8, 0,0,1,0,0, "load8");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd7, 0,0,1,0,0, "run_7");
    cyc(1, 0,1,1,0, 4'd0, 0,  4'd7, 0,0,0,0,0, "stop_at7");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd7, 0,0,0,0,0, "idle_hold");
    cyc(1, 1,1,1,0, 4'd0, 0,  4'd7, 0,0,0,0,0, "start_stop");

    // Reset while at 0 in RUN
    cyc(1, 1,0,0,0, 4'd0, 0,  4'd7, 0,0,1,0,0, "start_en0");
    cyc(1, 0,0,0,1, 4'd1, 0,  4'd1, 0,0,1,0,0, "load1");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd0, 1,0,1,0,0, "run_0");
    begin
      exp_t x;
      @(negedge clk);
      rstn = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b1; load = 1'b0;
      #1;
      check("async_rst", {count, tc, borrow, busy, done, load_err}, {4'd13, 5'b00000});
      x.v  = {4'd13, 5'b00000};
      x.nm = "rst_mid";
      exp_q.push_back(x);
    end
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd13, 0,0,0,0,0, "post_rst");
    cyc(1, 0,0,1,0, 4'd0, 0,  4'd13, 0,0,0,0,0, "post_rst2");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_n_down_counter.md
Name: mod_n_down_counter

Overview:
- Synchronous, fully clocked modulo-N down counter. It is the counting-direction complement of the team's ripple up counter.
- Counts MODULUS-1 down to 0, then wraps, or stops in one-shot mode.
- Provides parallel load, terminal-count flag, registered borrow pulse for cascading, and a small run-control state machine.
- Used as a timeout/interval generator and as the low digit of cascaded down-count chains.

Parameters:
- WIDTH, 4, counter register width in bits
- MODULUS, 14, count modulus; legal range 2..2**WIDTH
- ONESHOT_DEFAULT, 0, value of mode bit after reset (0 = wrap, 1 = one-shot)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  reset, asynchronous, active-low
- start  input  1  leave IDLE/DONE and begin counting from current value
- stop  input  1  return to IDLE, hold count
- en  input  1  count-enable qualifier; a decrement occurs only when en=1 in RUN
- load  input  1  synchronous parallel load request
- load_val  input  WIDTH  value to load
- oneshot  input  1  sampled on start; 1 = stop at 0 (DONE), 0 = wrap
- count  output  WIDTH  current count (registered)
- tc  output  1  combinational: count==0 and state==RUN
- borrow  output  1  registered one-cycle pulse on each 0 -> wrap/stop decrement
- busy  output  1  state==RUN
- done  output  1  state==DONE
- load_err  output  1  sticky: a load_val >= MODULUS was seen; cleared by next legal load or reset

Behaviour:
- Reset (async, rstn=0):
  - count=MODULUS-1, state=IDLE, borrow=0, load_err=0, oneshot latch=ONESHOT_DEFAULT.
  - Reset deassertion is synchronised by the integrator. Reset mid-count aborts immediately, with no borrow.
- States:
  - IDLE: count held.
  - RUN: decrement when en=1.
  - DONE: one-shot reached 0; count held at 0.
- Transitions:
  - IDLE->RUN on start.
  - DONE->RUN on start.
  - RUN->IDLE on stop.
  - RUN->DONE when decrementing from 0 with oneshot latch=1.
  - DONE->IDLE on stop.
  - start and stop in the same cycle: stop wins.
- Priority per cycle: stop > load > decrement.
  - load is accepted in every state.
  - A load does not change state.
  - A load in RUN suppresses that cycle's decrement.
- Load:
  - load_val < MODULUS: count <= load_val, load_err <= 0.
  - Otherwise: count <= MODULUS-1, load_err <= 1.
- Decrement in RUN with en=1:
  - count>0: count-1, borrow=0.
  - count==0, wrap mode: count <= MODULUS-1, borrow pulses 1 the next cycle, state stays RUN.
  - count==0, one-shot: count stays 0, borrow pulses, state <- DONE.
- Decrement in RUN with en=0: count held, borrow=0, tc still valid.
- Latency:
  - count updates 1 cycle after the qualifying edge.
  - borrow is asserted in the cycle after count wrapped.
  - tc is same-cycle combinational.
- start while in RUN is ignored; the oneshot latch is not resampled.
- Arithmetic is unsigned WIDTH-bit. count never leaves 0..MODULUS-1.

Optional Feature:
- MOD_N_DOWN_COUNTER_UPDN_EN defined:
  - Adds input port up (1 bit). When up=1 the counter increments, MODULUS-1 -> 0 wrap.
  - borrow doubles as carry.
  - One-shot terminates at MODULUS-1.
  - tc = (up ? count==MODULUS-1 : count==0) in RUN.
- Undefined: port absent; down-count only as above.

Decomposition:
- Shared package mod_cnt_pkg holds:
  - typedef enum of states {IDLE, RUN, DONE}, 2-bit encoding 00/01/10;
  - localparam function computing the clamped reload value.
- No sub-module is natural. State machine and datapath sit in one module; cascading is done by the instantiating level using borrow -> en.

Test Plan (MODULUS=14, WIDTH=4):
- Reset released, start, en=1, oneshot=0, 30 cycles:
  - count runs 13,12,...,0,13,...;
  - borrow pulses exactly once per 14 decrements;
  - tc high when count=0.
- start with oneshot=1 after load_val=3:
  - count 3,2,1,0, then 0 held;
  - done=1, busy=0, one borrow pulse;
  - a further start resumes from 0 and wraps/finishes immediately.
- load_val=15 in RUN -> count=13, load_err=1, no decrement that cycle. Then load_val=5 -> count=5, load_err=0.
- en toggled 1,0,1,0 from count=13 -> count 12,12,11,11.
- start and stop asserted together in IDLE -> stays IDLE. stop mid-RUN at count=7 -> count frozen at 7, tc=0.
- rstn pulsed low at count=0 in RUN -> immediate count=13, IDLE, borrow=0, no glitch pulse after release.
